// File: rtl/uart_rx_hex.sv
// 8N1 UART receiver with oversampled majority voting; holds the last good byte for the
// seven-segment display driver and pulses valid / frame_err per frame.
module uart_rx_hex #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] hex_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned ScW  = $clog2(OVERSAMPLE);

  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
  localparam logic [ScW-1:0]  ScLast = ScW'(OVERSAMPLE - 1);
  // Sample points are the ticks that advance sc to OVERSAMPLE/2-1, /2 and /2+1.
  localparam logic [ScW-1:0]  SmpA   = ScW'(OVERSAMPLE / 2 - 2);
  localparam logic [ScW-1:0]  SmpB   = ScW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScW-1:0]  SmpC   = ScW'(OVERSAMPLE / 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [ScW-1:0]  sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      smp_q, smp_d;
  logic            vote_q, vote_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hex_q, hex_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  logic rxs, tick, maj3, bit_end;

  assign rxs     = sync_q[1];
  assign tick    = (div_q == DivMax);
  assign maj3    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign bit_end = tick && (sc_q == ScLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sc_d    = sc_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    vote_d  = vote_q;
    shift_d = shift_q;
    hex_d   = hex_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != StIdle && state_q != StBreak) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sc_d = (sc_q == ScLast) ? '0 : sc_q + 1'b1;
        if (sc_q == SmpA) smp_d[0] = rxs;
        if (sc_q == SmpB) smp_d[1] = rxs;
        if (sc_q == SmpC) vote_d = maj3;
      end
    end

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        sc_d  = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (bit_end) begin
          if (!vote_q) begin
            state_d = StData;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {vote_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        // Decide at the centre vote so IDLE is re-entered before the stop bit ends.
        if (tick && sc_q == SmpC) begin
          div_d = '0;
          sc_d  = '0;
          if (maj3) begin
            hex_d   = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        div_d = '0;
        sc_d  = '0;
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      div_q   <= '0;
      sc_q    <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      vote_q  <= 1'b0;
      shift_q <= '0;
      hex_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_i};
      div_q   <= div_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      vote_q  <= vote_d;
      shift_q <= shift_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign hex_o       = hex_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_hex.sv
// Randomised bench for uart_rx_hex: frames are driven bit by bit and compared against a
// byte-level model (expected byte queue, last good byte, framing-error count).
module tb_uart_rx_hex;

  // Clock chosen so the divider is 12 at 115200 baud: same protocol, shorter frames.
  localparam int unsigned CLK_HZ = 22_118_400;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned OS     = 16;
  localparam int unsigned DIV    = CLK_HZ / (BAUD * OS);
  localparam int unsigned BIT    = DIV * OS;
  // Start detect (3) + 9 bits + stop-centre vote tick, then the output edge.
  localparam int unsigned LAT    = 3 + 9 * BIT + (OS / 2 + 1) * DIV + 1;
  localparam int unsigned FAST   = (BIT * 97 + 50) / 100;
  localparam int unsigned SLOW   = (BIT * 103 + 50) / 100;

  logic       clk_i;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] hex_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx_hex #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .hex_o       (hex_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc = 0;
  int unsigned n_valid = 0;
  int unsigned n_ferr  = 0;
  int unsigned n_both  = 0;
  int unsigned n_badhex = 0;
  int unsigned last_valid_cyc = 0;
  logic [7:0]  hex_prev = 8'h00;
  logic [7:0]  got_q[$];

  // Reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_hex = 8'h00;
  int unsigned exp_ferr = 0;
  int unsigned t_start = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o) begin
      got_q.push_back(hex_o);
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err_o) n_ferr <= n_ferr + 1;
    if (valid_o && frame_err_o) n_both <= n_both + 1;
    if (hex_o != hex_prev && !valid_o) n_badhex <= n_badhex + 1;
    hex_prev <= hex_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx_i = v;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int unsigned bclk, input logic stop_v,
                      input logic chk_busy);
    t_start = cyc;
    rx_i = 1'b0;
    for (int i = 0; i < int'(bclk); i++) begin
      @(posedge clk_i);
      #1;
      if (chk_busy && i == 1) check("busy_before_detect", busy_o, 0);
      if (chk_busy && i == 2) check("busy_rise", busy_o, 1);
    end
    for (int k = 0; k < 8; k++) hold(b[k], bclk);
    hold(stop_v, bclk);
    if (stop_v) begin
      exp_q.push_back(b);
      exp_hex = b;
    end else begin
      exp_ferr++;
    end
  endtask

  initial begin
    int unsigned v0, f0, lat, nmin;
    logic [7:0] b;
    logic       sv;

    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 2);
    check("rst_hex", hex_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_busy", busy_o, 0);

    // Reset in the middle of a frame
    hold(1'b0, BIT);
    hold(1'b1, BIT / 2);
    check("midframe_busy", busy_o, 1);
    rst_n = 1'b0;
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 1);
    check("midrst_hex", hex_o, 8'h00);
    check("midrst_valid", valid_o, 0);
    check("midrst_ferr", frame_err_o, 0);
    check("midrst_busy", busy_o, 0);
    hold(1'b1, 2 * BIT);
    check("midrst_no_valid", n_valid, 0);
    check("midrst_no_ferr", n_ferr, 0);

    // Single byte with latency check
    send(8'hA5, BIT, 1'b1, 1'b1);
    hold(1'b1, 50);
    check("a5_count", n_valid, 1);
    check("a5_hex", hex_o, 8'hA5);
    lat = last_valid_cyc - t_start;
    check("a5_latency", (lat + 3 >= LAT && lat <= LAT + 3) ? LAT : lat, LAT);

    // Back-to-back with no idle
    send(8'h00, BIT, 1'b1, 1'b0);
    send(8'hFF, BIT, 1'b1, 1'b0);
    send(8'h3C, BIT, 1'b1, 1'b0);
    hold(1'b1, 50);
    check("b2b_count", n_valid, 4);
    check("b2b_hex", hex_o, 8'h3C);

    // Short low glitch
    v0 = n_valid;
    f0 = n_ferr;
    hold(1'b0, BIT / 4);
    hold(1'b1, 2 * BIT);
    check("glitch_valid", n_valid, v0);
    check("glitch_ferr", n_ferr, f0);
    check("glitch_hex", hex_o, exp_hex);
    check("glitch_busy", busy_o, 0);

    // Framing error then held-low break
    send(8'h55, BIT, 1'b0, 1'b0);
    hold(1'b0, 5000);
    check("fe_count", n_ferr, exp_ferr);
    check("fe_hex_kept", hex_o, exp_hex);
    check("fe_break_busy", busy_o, 1);
    hold(1'b1, BIT);
    check("fe_break_exit", busy_o, 0);
    send(8'h12, BIT, 1'b1, 1'b0);
    hold(1'b1, 50);
    check("fe_recover_hex", hex_o, 8'h12);

    // Rate skew +/-3%
    send(8'hC3, SLOW, 1'b1, 1'b0);
    hold(1'b1, 50);
    check("skew_slow_hex", hex_o, 8'hC3);
    check("skew_slow_count", n_valid, exp_q.size());
    send(8'hC3, FAST, 1'b1, 1'b0);
    hold(1'b1, 50);
    check("skew_fast_count", n_valid, exp_q.size());
    check("skew_ferr", n_ferr, exp_ferr);

    // Random frames
    for (int r = 0; r < 16; r++) begin
      b  = 8'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      send(b, $urandom_range(FAST, SLOW), sv, 1'b0);
      if (!sv) begin
        hold(1'b0, $urandom_range(0, 400));
        hold(1'b1, BIT);
      end
      hold(1'b1, $urandom_range(0, 300));
      check("rnd_hex", hex_o, exp_hex);
    end

    hold(1'b1, 50);
    check("total_valid", n_valid, exp_q.size());
    check("total_ferr", n_ferr, exp_ferr);
    check("total_bytes", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < int'(nmin); i++) check("byte_seq", got_q[i], exp_q[i]);
    check("valid_ferr_overlap", n_both, 0);
    check("hex_change_without_valid", n_badhex, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex.md
# uart_rx_hex

Serial byte receiver that sits directly upstream of the two-digit seven-segment display driver. It deserialises 8N1 UART frames arriving on a Pmod pin and holds the last correctly framed byte on `hex[7:0]`, which connects straight to the display driver's `hex` input. It also flags each new byte and each framing error for status LEDs or counters.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- `OVERSAMPLE`, default 16: ticks per bit. Must be ≥ 8 and even.
- `clk` in 1: system clock. All logic is in this single clock domain.
- `rst_n` in 1: asynchronous, active-low reset. Deassertion is used as-is and is not synchronised inside this block.
- `rx` in 1: asynchronous serial input. Idles high.
- `hex` out 8: last good received byte. Drives the display `hex` input.
- `valid` out 1: one-cycle pulse when `hex` is updated.
- `frame_err` out 1: one-cycle pulse when a frame is rejected at its stop bit.
- `busy` out 1: high while any frame is in progress, i.e. in any state other than IDLE.

## Operation
- **Input synchroniser:** `rx` passes through 2 flops, both reset to 1. All logic below uses the synchronised value `rxs`.
- **Tick divider:** `DIV = CLK_HZ / (BAUD*OVERSAMPLE)`, integer-truncated, with `DIV ≥ 2`. For the defaults, `DIV` = 54 and one bit = 864 clocks.
  - A tick fires when the divider reaches `DIV-1`; the divider then wraps to 0.
  - In IDLE, both the divider and the tick counter `sc` (range 0..OVERSAMPLE-1) are held at 0.
- **Majority vote:** each bit is sampled at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`. The bit value is the majority of the three samples.
- **State machine:** states are IDLE, START, DATA, STOP and BREAK.
  - **IDLE:** waits for `rxs`=0. On the first cycle it is low, go to START with divider = 0 and `sc` = 0.
  - **START:** at `sc` = OVERSAMPLE-1, if the majority vote = 0, go to DATA with bit index = 0. Otherwise the low pulse was a glitch: return to IDLE with no output pulse.
  - **DATA:** data is LSB first. At the end of each bit period, shift the voted bit into shift register bit [7] (shift right). After bit index 7, go to STOP.
  - **STOP:** the stop bit is evaluated at its centre vote, tick `OVERSAMPLE/2+1`; the block does not wait for the full stop period.
    - Vote = 1: `hex` ← shift register, `valid`=1 for one cycle, go to IDLE.
    - Vote = 0: `frame_err`=1 for one cycle, `hex` is unchanged, go to BREAK.
  - **BREAK:** waits until `rxs`=1, then goes to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- **Output behaviour:**
  - `hex` changes only on a `valid` pulse.
  - `valid` and `frame_err` are never high in the same cycle.
- **Reset values:** state IDLE, `hex`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, synchroniser = 1, shift register = 0, counters = 0.
- **Reset mid-frame:** the partial frame is discarded and no pulse is generated. After release, a line that is still low mid-frame is treated as a start bit. Any garbage this causes is either rejected by the start-bit vote or ends in `frame_err`.

## Timing
- **Start-edge latency:** the synchroniser adds 2 clocks. `busy` rises 3 clocks after the `rx` falling edge.
- **Stop-decision latency:** `valid` or `frame_err` rises on the clock edge after the stop-bit centre vote completes. At the defaults this is about 9.56 bit periods after the `rx` falling edge, giving 8266 ± 3 clocks.
  - The `hex` update and the `valid` pulse happen on the same clock edge.
  - `busy` falls on the same edge as the `valid` pulse.
- **Back-to-back frames:** a start bit immediately after a stop bit is detected, since IDLE is re-entered half a bit before the stop bit ends.
- **Rate tolerance:** transmitter rate error of at least ±3% must be received correctly at the defaults.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame, release with `rx`=1 → `hex`=8'h00, `valid`=0, `frame_err`=0, `busy`=0. No pulse appears until a new full frame is sent.
- **Single byte:** send 0xA5 at 115200 baud → exactly one `valid` pulse within 8266±3 clocks of the start edge, and `hex`=8'hA5 afterwards.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with zero idle between frames → three `valid` pulses, and `hex` sequence 00, FF, 3C.
- **Glitch:** hold `rx` low for 200 clocks, then high → return to IDLE, no `valid`, no `frame_err`, `hex` unchanged.
- **Framing error:** send 0x55 with the stop bit driven low, then hold low for 5000 clocks, then high, then send 0x12:
  - one `frame_err` pulse;
  - `hex` keeps its prior value throughout the break;
  - then `valid` with `hex`=8'h12.
- **Rate skew:** send 0xC3 at baud +3% and then at −3% → both frames are received as 8'hC3 with no `frame_err`.
